fifo_stream: RTL

- Parametrised successor to the team's small PS-PL FIFO: synchronous single-clock buffer on the PS-PL data path.
- Stores exactly DEPTH entries, with no wasted slot. Any DEPTH ≥ 2 is allowed, including non-power-of-2.
- Head is presented first-word-fall-through from a registered output stage.
- Adds an occupancy count, almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_stream_if.sv | 33 +++
 rtl/fifo_ram.sv | 24 ++
 rtl/fifo_stream.sv | 103 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the PS-PL FIFO family: pointer/count widths and
// the bit positions of the sticky error flags.
package fifo_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;
  localparam int ERR_W   = 2;

  // Address width for n cells; never below one bit so a 1-cell RAM still has a port.
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_stream_if.sv
// Push/pop/status bundle of fifo_stream; master drives requests, slave is the FIFO.
interface fifo_stream_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] datain;
  logic             enw;
  logic             full;
  logic             almost_full;
  logic [WIDTH-1:0] dataout;
  logic             valid;
  logic             enr;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             flush;
  logic             overflow;
  logic             underflow;

  modport master (
    output datain, enw, enr, flush,
    input  full, almost_full, dataout, valid, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  datain, enw, enr, flush,
    output full, almost_full, dataout, valid, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 63
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_stream.sv
// Single-clock FWFT FIFO: DEPTH-1 RAM cells plus a registered head stage,
// with occupancy count, threshold flags, sticky errors and synchronous flush.
module fifo_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 64,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_stream_if.slave  bus
);

  localparam int RAM_D = DEPTH - 1;
  localparam int PW    = ptr_w(RAM_D);
  localparam int CW    = cnt_w(DEPTH);
  localparam int RCW   = cnt_w(RAM_D);

  generate
    if (DEPTH < 2 || AEMPTY_TH >= AFULL_TH) begin : g_bad_cfg
      $fatal(1, "fifo_stream: DEPTH must be >= 2 and AEMPTY_TH < AFULL_TH");
    end
  endgenerate

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [RCW-1:0]   ram_cnt;
  logic [CW-1:0]    count_q;
  logic             valid_q;
  logic [WIDTH-1:0] dout_q;
  logic [ERR_W-1:0] err_q;
  logic [WIDTH-1:0] ram_rdata;

  logic full_c;
  logic push_ok;
  logic pop_ok;
  logic load;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RAM_D - 1)) ? '0 : p + PW'(1);
  endfunction

  // full depends only on registered count, so a pop never frees a slot for the same-edge push
  assign full_c  = (count_q == CW'(DEPTH));
  assign push_ok = bus.enw && !full_c;
  assign pop_ok  = bus.enr && valid_q;
  assign load    = (ram_cnt != '0) && (!valid_q || pop_ok);

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (RAM_D)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok && !bus.flush),
    .waddr (wr_ptr),
    .wdata (bus.datain),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      err_q   <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (load) begin
        rd_ptr <= ptr_inc(rd_ptr);
        dout_q <= ram_rdata;
      end
      ram_cnt <= ram_cnt + RCW'(push_ok) - RCW'(load);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      if (load)        valid_q <= 1'b1;
      else if (pop_ok) valid_q <= 1'b0;
      if (bus.enw && full_c)   err_q[ERR_OVF] <= 1'b1;
      if (bus.enr && !valid_q) err_q[ERR_UNF] <= 1'b1;
    end
  end

  assign bus.full         = full_c;
  assign bus.almost_full  = (count_q >= CW'(AFULL_TH));
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign bus.dataout      = dout_q;
  assign bus.valid        = valid_q;
  assign bus.count        = count_q;
  assign bus.overflow     = err_q[ERR_OVF];
  assign bus.underflow    = err_q[ERR_UNF];

endmodule
